// File: rtl/lif_neuron_multi.sv
// Multi-input leaky integrate-and-fire neuron with saturating membrane,
// shift leak, absolute refractory period and a saturating spike counter.
module lif_neuron_multi #(
  parameter int N_IN       = 4,
  parameter int W          = 8,
  parameter int VW         = 12,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 4,
  parameter int RESET_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_IN*W-1:0] in_data,
  input  logic [N_IN-1:0]   in_valid,
  input  logic [VW-1:0]     threshold,
  output logic              spike,
  output logic [VW-1:0]     vmem,
  output logic              refractory,
  output logic [15:0]       spike_count
);

  localparam int SW = W + $clog2(N_IN);
  localparam int CW = (REFRAC > 1) ? $clog2(REFRAC + 1) : 1;

  typedef enum logic {ACTIVE = 1'b0, REFR = 1'b1} state_t;

  function automatic logic [VW-1:0] sat_vmem(input logic [VW:0] v);
    return v[VW] ? {VW{1'b1}} : v[VW-1:0];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [VW-1:0] vmem_nxt;
  logic          spike_nxt;
  logic [15:0]   count_nxt;

  logic [SW-1:0] sum;
  logic [VW-1:0] leak;
  logic [VW-1:0] v_leaked;
  logic [VW:0]   v_raw;
  logic [VW-1:0] v_sat;
  logic [VW-1:0] residual;
  logic          fire;

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (in_valid[i]) sum = sum + SW'(in_data[i*W +: W]);
    end
  end

  // Leak never exceeds vmem, so the subtraction stays non-negative; one
  // extra bit on the add catches overflow for saturation.
  assign leak     = (LEAK_SHIFT == 0) ? '0 : (vmem >> LEAK_SHIFT);
  assign v_leaked = vmem - leak;
  assign v_raw    = {1'b0, v_leaked} + {{(VW + 1 - SW){1'b0}}, sum};
  assign v_sat    = sat_vmem(v_raw);
  assign fire     = (v_sat >= threshold);
  assign residual = v_sat - threshold;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    vmem_nxt  = vmem;
    spike_nxt = 1'b0;
    count_nxt = spike_count;
    if (en) begin
      case (state)
        ACTIVE: begin
          if (fire) begin
            spike_nxt = 1'b1;
            vmem_nxt  = (RESET_MODE == 1) ? residual : '0;
            count_nxt = sat_inc16(spike_count);
            if (REFRAC > 0) begin
              state_nxt = REFR;
              cnt_nxt   = CW'(REFRAC);
            end
          end else begin
            vmem_nxt = v_sat;
          end
        end
        REFR: begin
          cnt_nxt = cnt - CW'(1);
          if (cnt == CW'(1)) state_nxt = ACTIVE;
        end
        default: state_nxt = ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACTIVE;
      cnt         <= '0;
      vmem        <= '0;
      spike       <= 1'b0;
      spike_count <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      vmem        <= vmem_nxt;
      spike       <= spike_nxt;
      spike_count <= count_nxt;
    end
  end

  assign refractory = (state == REFR);

endmodule
